// File: rtl/capture_pkg.sv
// Types and constants shared between the trace capture engine and the trace dump reader.
package capture_pkg;

    localparam int TRACE_ADDR_W = 9;
    localparam int TRACE_DEPTH  = 512;
    localparam int NUM_CH       = 5;

    typedef logic [TRACE_ADDR_W-1:0] Address;

    // Kept distinct from the capture engine's State enum so both can live in one scope.
    typedef enum logic [2:0] {
        DMP_IDLE,
        DMP_RD,
        DMP_WAIT,
        DMP_SEND,
        DMP_DONE
    } DumpState;

endpackage

// File: rtl/dump_ch_mux.sv
// Selects one channel's byte from a packed multi-channel RAM word; out-of-range channels read as zero.
module dump_ch_mux #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = capture_pkg::NUM_CH,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    input  logic [CH_W-1:0]          ch,
    output logic [DATA_W-1:0]        data
);

    logic [DATA_W-1:0] lanes [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        assign lanes[gi] = rdata[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) begin
                data = lanes[k];
            end
        end
    end

endmodule

// File: rtl/trace_dump.sv
// Reads the whole circular trace RAM for one channel, oldest sample first, and hands each
// byte to the transmitter over a valid/ack handshake.
module trace_dump #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int NUM_CH = capture_pkg::NUM_CH,
    parameter int CH_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     capture_done,
    input  logic                     start_dump,
    input  logic [CH_W-1:0]          dump_channel,
    input  logic [ADDR_W-1:0]        trace_end,
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    output logic                     en,
    output logic [ADDR_W-1:0]        addr,
    output logic                     send_dump,
    output logic [DATA_W-1:0]        dump_data,
    input  logic                     dump_ack,
    output logic                     dump_finished,
    output logic                     busy
);

    import capture_pkg::DumpState;
    import capture_pkg::DMP_IDLE;
    import capture_pkg::DMP_RD;
    import capture_pkg::DMP_WAIT;
    import capture_pkg::DMP_SEND;
    import capture_pkg::DMP_DONE;

    DumpState          state_reg, state_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [CH_W-1:0]   ch_reg, ch_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] lane_data;

    dump_ch_mux #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_ch_mux (
        .rdata (rdata),
        .ch    (ch_reg),
        .data  (lane_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= DMP_IDLE;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            ch_reg     <= '0;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            rd_ptr_reg <= rd_ptr_next;
            cnt_reg    <= cnt_next;
            ch_reg     <= ch_next;
            data_reg   <= data_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        cnt_next    = cnt_reg;
        ch_next     = ch_reg;
        data_next   = data_reg;
        case (state_reg)
            DMP_IDLE: begin
                if (start_dump && capture_done) begin
                    ch_next     = dump_channel;
                    rd_ptr_next = trace_end;
                    cnt_next    = '0;
                    state_next  = DMP_RD;
                end
            end
            DMP_RD: begin
                state_next = DMP_WAIT;
            end
            DMP_WAIT: begin
                data_next  = lane_data;
                state_next = DMP_SEND;
            end
            DMP_SEND: begin
                // Terminal count is tested before incrementing, so cnt never wraps.
                if (dump_ack) begin
                    if (cnt_reg == '1) begin
                        state_next = DMP_DONE;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                        cnt_next    = cnt_reg + 1'b1;
                        state_next  = DMP_RD;
                    end
                end
            end
            DMP_DONE: begin
                state_next = DMP_IDLE;
            end
            default: begin
                state_next = DMP_IDLE;
            end
        endcase
    end

    assign en            = (state_reg == DMP_RD);
    assign addr          = rd_ptr_reg;
    assign send_dump     = (state_reg == DMP_SEND);
    assign dump_data     = data_reg;
    assign dump_finished = (state_reg == DMP_DONE);
    assign busy          = (state_reg != DMP_IDLE);

endmodule
